// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the rv32i fetch sequencer: state encodings, instruction size,
// default reset vector and the alignment helper.
package pc_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FetchBoot  = 2'd0,
    FetchFetch = 2'd1,
    FetchHold  = 2'd2,
    FetchTrap  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] InstrBytes         = 32'd4;
  localparam logic [31:0] DefaultResetVector = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of the fetch sequencer's memory, decode and redirect handshakes.
// The master modport is the sequencer itself; slave is memory/decode/execute.
interface pc_fetch_sequencer_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        misaligned;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    input  redirect,
    input  redirect_target,
    output pc,
    output misaligned
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    output redirect,
    output redirect_target,
    input  pc,
    input  misaligned
  );

endinterface

// File: rtl/pc_fetch_sequencer_pc_reg.sv
// Program counter register: synchronous active-high reset to ResetVector, load-enabled update.
module pc_reg
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] ResetVector = DefaultResetVector
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_q_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= ResetVector;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_q_o = pc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: owns the PC, sequences imem req/ack and decode valid/ready,
// applies execute redirects and traps on misaligned targets.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] ResetVector = DefaultResetVector
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  pc_fetch_sequencer_if.master        bus_io
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  pc_q, pc_d;
  logic         pc_load;

  pc_reg #(
    .ResetVector(ResetVector)
  ) u_pc_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (pc_load),
    .pc_d_i (pc_d),
    .pc_q_o (pc_q)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_d       = pc_q + InstrBytes;
    pc_load    = 1'b0;

    unique case (state_q)
      FetchBoot: state_d = FetchFetch;
      FetchFetch: begin
        if (bus_io.imem_ack) begin
          instr_d    = bus_io.imem_rdata;
          instr_pc_d = pc_q;
          pc_load    = 1'b1;
          state_d    = FetchHold;
        end
      end
      FetchHold: begin
        if (bus_io.instr_ready) begin
          state_d = FetchFetch;
        end
      end
      FetchTrap: state_d = FetchTrap;
    endcase

    // Redirect overrides any ack/ready this cycle; returned rdata is dropped.
    if ((state_q != FetchTrap) && bus_io.redirect) begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      if (is_word_aligned(bus_io.redirect_target)) begin
        pc_d    = bus_io.redirect_target;
        pc_load = 1'b1;
        state_d = FetchFetch;
      end else begin
        pc_load = 1'b0;
        state_d = FetchTrap;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= FetchBoot;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Handshake outputs decode from the state register only, so no input reaches an output.
  assign bus_io.imem_req    = (state_q == FetchFetch);
  assign bus_io.imem_addr   = pc_q;
  assign bus_io.instr_valid = (state_q == FetchHold);
  assign bus_io.instr       = instr_q;
  assign bus_io.instr_pc    = instr_pc_q;
  assign bus_io.pc          = pc_q;
  assign bus_io.misaligned  = (state_q == FetchTrap);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed stimulus pushes expected fetches and
// deliveries, a negedge monitor pops and compares them; a second instance covers PC wrap.
module tb_pc_fetch_sequencer;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_instr_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] exp_addr[$];
  exp_instr_t  exp_instr[$];

  pc_fetch_sequencer_if ifa ();
  pc_fetch_sequencer_if ifb ();

  pc_fetch_sequencer #(
    .ResetVector(32'h0000_0000)
  ) u_dut_a (
    .clk_i  (clk),
    .reset_i(rst_a),
    .bus_io (ifa)
  );

  pc_fetch_sequencer #(
    .ResetVector(32'hFFFF_FFFC)
  ) u_dut_b (
    .clk_i  (clk),
    .reset_i(rst_b),
    .bus_io (ifb)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
  endfunction

  assign ifa.imem_rdata = mem_word(ifa.imem_addr);
  assign ifb.imem_rdata = mem_word(ifb.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: accepted fetches and consumed instructions are matched against the queues.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (ifa.imem_req && ifa.imem_ack && !ifa.redirect) begin
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected actual=%h expected=none", ifa.imem_addr);
        end else begin
          check("fetch_addr", ifa.imem_addr, exp_addr.pop_front());
        end
      end
      if (ifa.instr_valid && ifa.instr_ready) begin
        if (exp_instr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL instr_unexpected actual=%h expected=none", ifa.instr_pc);
        end else begin
          exp_instr_t e;
          e = exp_instr.pop_front();
          check("instr_word", ifa.instr, e.word);
          check("instr_pc", ifa.instr_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.imem_ack = 1'b0;
    ifa.instr_ready = 1'b0;
    ifa.redirect = 1'b0;
    ifa.redirect_target = 32'h0;
    ifb.imem_ack = 1'b1;
    ifb.instr_ready = 1'b1;
    ifb.redirect = 1'b0;
    ifb.redirect_target = 32'h0;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    check("rst_req", {31'b0, ifa.imem_req}, 32'd0);
    check("rst_valid", {31'b0, ifa.instr_valid}, 32'd0);
    check("rst_mis", {31'b0, ifa.misaligned}, 32'd0);
    check("rst_pc", ifa.pc, 32'h0);
    check("rst_instr", ifa.instr, 32'h0);
    check("rst_instr_pc", ifa.instr_pc, 32'h0);
    tick();

    // Zero-wait streaming: 0, 4, 8, 12 with a request every other cycle
    for (int k = 0; k < 4; k++) begin
      exp_addr.push_back(32'(4 * k));
      exp_instr.push_back('{word: mem_word(32'(4 * k)), pc: 32'(4 * k)});
    end
    rst_a = 1'b0;
    ifa.imem_ack = 1'b1;
    ifa.instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("stream_req", {31'b0, ifa.imem_req}, (i == 0) ? 32'd0 : 32'(i % 2));
      if (i > 0 && (i % 2) == 1) check("stream_addr", ifa.imem_addr, 32'(2 * (i - 1)));
      if (i > 0 && (i % 2) == 0) check("stream_ipc", ifa.instr_pc, 32'(2 * (i - 2)));
    end
    tick();
    ifa.imem_ack = 1'b0;
    ifa.instr_ready = 1'b0;

    // Slow memory and stalled decode at address 16
    exp_addr.push_back(32'd16);
    exp_instr.push_back('{word: mem_word(32'd16), pc: 32'd16});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_addr", ifa.imem_addr, 32'd16);
      check("wait_req", {31'b0, ifa.imem_req}, 32'd1);
      tick();
    end
    ifa.imem_ack = 1'b1;
    tick();
    ifa.imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, ifa.instr_valid}, 32'd1);
      check("stall_instr", ifa.instr, mem_word(32'd16));
      check("stall_ipc", ifa.instr_pc, 32'd16);
      check("stall_pc", ifa.pc, 32'd20);
      tick();
    end
    ifa.instr_ready = 1'b1;
    tick();
    ifa.instr_ready = 1'b0;
    @(negedge clk);
    check("after_stall_addr", ifa.imem_addr, 32'd20);
    tick();

    // Redirect together with instr_ready in HOLD
    exp_addr.push_back(32'd20);
    exp_instr.push_back('{word: mem_word(32'd20), pc: 32'd20});
    ifa.imem_ack = 1'b1;
    tick();
    ifa.imem_ack = 1'b0;
    ifa.redirect = 1'b1;
    ifa.redirect_target = 32'h0000_0100;
    ifa.instr_ready = 1'b1;
    tick();
    ifa.redirect = 1'b0;
    ifa.instr_ready = 1'b0;
    @(negedge clk);
    check("redir_addr", ifa.imem_addr, 32'h100);
    check("redir_req", {31'b0, ifa.imem_req}, 32'd1);
    check("redir_valid", {31'b0, ifa.instr_valid}, 32'd0);
    tick();

    // Redirect beats ack in FETCH; rdata discarded
    ifa.imem_ack = 1'b1;
    ifa.redirect = 1'b1;
    ifa.redirect_target = 32'h0000_0200;
    tick();
    ifa.imem_ack = 1'b0;
    ifa.redirect = 1'b0;
    @(negedge clk);
    check("race_addr", ifa.imem_addr, 32'h200);
    check("race_valid", {31'b0, ifa.instr_valid}, 32'd0);
    check("race_instr", ifa.instr, mem_word(32'd20));
    check("race_ipc", ifa.instr_pc, 32'd20);
    tick();

    // Misaligned redirect traps; later redirects ignored; reset clears
    ifa.redirect = 1'b1;
    ifa.redirect_target = 32'h0000_0102;
    tick();
    ifa.redirect_target = 32'h0000_0300;
    ifa.imem_ack = 1'b1;
    @(negedge clk);
    check("trap_mis", {31'b0, ifa.misaligned}, 32'd1);
    check("trap_req", {31'b0, ifa.imem_req}, 32'd0);
    check("trap_valid", {31'b0, ifa.instr_valid}, 32'd0);
    check("trap_pc", ifa.pc, 32'h200);
    tick();
    @(negedge clk);
    check("trap_stay_mis", {31'b0, ifa.misaligned}, 32'd1);
    check("trap_stay_pc", ifa.pc, 32'h200);
    check("trap_stay_req", {31'b0, ifa.imem_req}, 32'd0);
    tick();
    ifa.redirect = 1'b0;
    ifa.imem_ack = 1'b0;
    rst_a = 1'b1;
    tick();
    @(negedge clk);
    check("trap_rst_mis", {31'b0, ifa.misaligned}, 32'd0);
    check("trap_rst_pc", ifa.pc, 32'h0);
    check("trap_rst_req", {31'b0, ifa.imem_req}, 32'd0);
    tick();

    // Reset while waiting for ack; late ack ignored
    rst_a = 1'b0;
    tick();
    @(negedge clk);
    check("pre_abort_req", {31'b0, ifa.imem_req}, 32'd1);
    tick();
    rst_a = 1'b1;
    tick();
    @(negedge clk);
    check("abort_req", {31'b0, ifa.imem_req}, 32'd0);
    tick();
    rst_a = 1'b0;
    ifa.imem_ack = 1'b1;
    tick();
    ifa.imem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", {31'b0, ifa.imem_req}, 32'd1);
    check("late_ack_valid", {31'b0, ifa.instr_valid}, 32'd0);
    check("late_ack_addr", ifa.imem_addr, 32'h0);
    check("late_ack_instr", ifa.instr, 32'h0);
    tick();

    // Wrap from 0xFFFF_FFFC on the second instance
    rst_b = 1'b0;
    @(negedge clk);
    check("wrap_boot_req", {31'b0, ifb.imem_req}, 32'd0);
    tick();
    @(negedge clk);
    check("wrap_first_addr", ifb.imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    check("wrap_ipc", ifb.instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc", ifb.pc, 32'h0);
    tick();
    @(negedge clk);
    check("wrap_next_addr", ifb.imem_addr, 32'h0);
    check("wrap_next_req", {31'b0, ifb.imem_req}, 32'd1);
    tick();

    check("sb_addr_left", 32'(exp_addr.size()), 32'd0);
    check("sb_instr_left", 32'(exp_instr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Fetch controller for the rv32i datapath. It owns the program counter and sequences each PC update against an instruction-memory req/ack handshake and a decode-stage valid/ready handshake. It applies branch and jump redirects from execute and traps on misaligned targets. It sits between the PC register, instruction memory and the decode stage.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address, always equal to pc
- imem_ack  input  1  memory returns imem_rdata this cycle; only sampled while imem_req=1
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- instr_valid  output  1  instr/instr_pc hold a fetched instruction for decode
- instr  output  32  fetched instruction word
- instr_pc  output  32  address instr was fetched from
- instr_ready  input  1  decode accepts instr this cycle when instr_valid=1
- redirect  input  1  execute requests a PC change (taken branch, jal, jalr)
- redirect_target  input  32  new PC, valid when redirect=1
- pc  output  32  current program counter
- misaligned  output  1  sticky trap flag: a redirect target had bits [1:0] != 0

## Operation
- States: BOOT, FETCH, HOLD, TRAP.
- Reset (highest priority, any state): pc=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, imem_req=0, misaligned=0, state=BOOT.
- BOOT: all outputs are at their reset values. The next state is unconditionally FETCH.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: latch instr=imem_rdata and instr_pc=pc, set pc=pc+4, go to HOLD.
  - Without ack: stay in FETCH with the address stable.
- HOLD: imem_req=0, instr_valid=1, with instr and instr_pc stable.
  - On instr_ready: go to FETCH.
  - Otherwise stay in HOLD.
- Redirect (checked after reset, in BOOT/FETCH/HOLD):
  - If redirect_target[1:0]==0: pc=redirect_target, state=FETCH, instr_valid=0 next cycle.
  - If redirect_target[1:0]!=0: state=TRAP, misaligned=1, pc unchanged.
- TRAP: imem_req=0, instr_valid=0, misaligned=1. Only reset leaves TRAP; redirect is ignored.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.

## Timing
- All outputs are registered or decoded from the state register only. There are no combinational input-to-output paths.
- imem_ack at edge N: instr_valid=1 from cycle N+1.
- instr_ready at edge N: imem_req=1 from cycle N+1.
- Minimum of 2 cycles per instruction with zero-wait memory (ack in the first FETCH cycle).
- Redirect at edge N: imem_req=1 with imem_addr=target from cycle N+1.
- Simultaneous events:
  - redirect and imem_ack in FETCH: redirect wins and rdata is discarded.
  - redirect and instr_ready in HOLD: redirect wins; the held instruction counts as consumed.
  - reset together with anything: reset wins.
- Reset mid-fetch: the outstanding request is abandoned, and imem_req drops the next cycle.

## Structure
- Shared header rv32i_defs.vh holds:
  - the state encodings FETCH_BOOT, FETCH_FETCH, FETCH_HOLD, FETCH_TRAP (2 bits);
  - the constant INSTR_BYTES=4;
  - the default reset vector.
- One sub-module, pc_reg: 32-bit register with synchronous active-high reset to RESET_VECTOR, a load enable and a next-value input.
- The FSM, instruction latch and pc-next mux (pc+4 vs redirect_target) live in pc_fetch_sequencer.

## Test plan
- Reset release, RESET_VECTOR=0, ack tied 1, ready tied 1: imem_addr sequence is 0, 4, 8, 12, with a new imem_req every 2 cycles and instr_pc matching each address.
- Memory ack delayed 3 cycles, instr_ready held 0 for 4 cycles: imem_addr stays stable until ack, and instr/instr_pc stay stable while waiting. pc advances only once.
- Redirect to 32'h0000_0100 in HOLD together with instr_ready: the next imem_addr is 0x100, and instr_valid is 0 for the following cycle.
- Redirect to 32'h0000_0102: misaligned=1 next cycle. imem_req=0 and pc is unchanged until reset; reset clears misaligned and pc returns to RESET_VECTOR.
- RESET_VECTOR=32'hFFFF_FFFC, one fetch accepted: the next imem_addr is 0x0000_0000.
- Reset asserted while FETCH is waiting for ack: imem_req=0 the next cycle, and a late ack has no effect.
